fetch_queue: RTL and testbench

- Parametrised successor of the single-entry instruction fetcher.
- Decouples instruction-cache fetch from decode with a DEPTH-entry FIFO, so sequential prefetch continues while the decoder stalls.
- Supports two redirect sources: RoB clear (highest priority) and decoder predicted-taken redirect.
- Handles flushes that arrive while a cache request is in flight.
- Sits between the instruction cache and the Decoder.

---
 rtl/fetch_queue_if.sv | 33 +++
 rtl/fetch_queue.sv | 99 +++++++++
 tb/tb_fetch_queue.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: global ready, RoB redirect, cache handshake and decoder side.
interface fetch_queue_if #(
  parameter int DEPTH       = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                         rdy;
  logic                         rob_clear;
  logic [ADDR_WIDTH-1:0]        back_pc;
  logic                         fetch_req;
  logic [ADDR_WIDTH-1:0]        fetch_pc;
  logic                         fetch_resp_valid;
  logic [INSTR_WIDTH-1:0]       fetch_resp_instr;
  logic                         instr_valid;
  logic [INSTR_WIDTH-1:0]       instr;
  logic [ADDR_WIDTH-1:0]        instr_addr;
  logic                         instr_issued;
  logic                         pred_redirect;
  logic [ADDR_WIDTH-1:0]        pred_pc;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport slave (
    input  rdy, rob_clear, back_pc, fetch_resp_valid, fetch_resp_instr,
           instr_issued, pred_redirect, pred_pc,
    output fetch_req, fetch_pc, instr_valid, instr, instr_addr, count
  );

  modport master (
    output rdy, rob_clear, back_pc, fetch_resp_valid, fetch_resp_instr,
           instr_issued, pred_redirect, pred_pc,
    input  fetch_req, fetch_pc, instr_valid, instr, instr_addr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: sequential prefetch into a DEPTH-entry FIFO with
// RoB / predicted-taken redirects and discard of in-flight responses after a flush.
module fetch_queue #(
  parameter int                    DEPTH       = 4,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  addr;
  } entry_t;

  entry_t [DEPTH-1:0]    mem_q;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d, count_nx;
  logic                  req_q, req_d, drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, rpc_q, rpc_d, tgt;
  logic                  pop, resp, flush, wr_en;

  always_comb begin
    pop      = bus.instr_issued && (count_q != '0);
    flush    = bus.rob_clear || (pop && bus.pred_redirect);
    tgt      = bus.rob_clear ? bus.back_pc : bus.pred_pc;
    resp     = bus.fetch_resp_valid && req_q;
    wr_en    = resp && !flush && !drop_q;
    count_nx = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    req_d    = req_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    rpc_d    = rpc_q;
    if (flush) begin
      head_d  = tail_q;
      count_d = '0;
      // An in-flight request can't be cancelled; remember the target and eat its response.
      if (!req_q || resp) begin
        pc_d   = tgt;
        req_d  = 1'b1;
        drop_d = 1'b0;
      end else begin
        drop_d = 1'b1;
        rpc_d  = tgt;
      end
    end else begin
      count_d = count_nx;
      if (pop)   head_d = head_q + PTR_W'(1);
      if (wr_en) tail_d = tail_q + PTR_W'(1);
      if (drop_q) begin
        if (resp) begin
          pc_d   = rpc_q;
          drop_d = 1'b0;
        end
      end else begin
        if (wr_en) pc_d = pc_q + ADDR_WIDTH'(4);
        if (count_nx < CNT_W'(DEPTH)) req_d = 1'b1;
        else if (wr_en)               req_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      req_q   <= 1'b1;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      rpc_q   <= '0;
    end else if (bus.rdy) begin
      if (wr_en) mem_q[tail_q] <= '{instr: bus.fetch_resp_instr, addr: pc_q};
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      req_q   <= req_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      rpc_q   <= rpc_d;
    end
  end

  assign bus.fetch_req   = req_q;
  assign bus.fetch_pc    = pc_q;
  assign bus.count       = count_q;
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr       = mem_q[head_q].instr;
  assign bus.instr_addr  = mem_q[head_q].addr;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then randomized traffic, all checked
// against a queue-based reference model of the fetch/redirect rules.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam logic [AW-1:0] RPC = '0;

  typedef struct {
    logic [IW-1:0] instr;
    logic [AW-1:0] addr;
  } ent_t;

  logic clk, rst;
  int   total, bad;

  fetch_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();
  fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(RPC))
    dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  ent_t          mq[$];
  logic          m_req, m_drop;
  logic [AW-1:0] m_pc, m_rpc;

  task automatic m_reset();
    mq.delete();
    m_req  = 1'b1;
    m_pc   = RPC;
    m_drop = 1'b0;
    m_rpc  = '0;
  endtask

  task automatic m_step();
    logic pop, hit, fl;
    logic [AW-1:0] tgt;
    ent_t e;
    if (!bus.rdy) return;
    pop = bus.instr_issued && (mq.size() > 0);
    hit = bus.fetch_resp_valid && m_req;
    fl  = bus.rob_clear || (pop && bus.pred_redirect);
    tgt = bus.rob_clear ? bus.back_pc : bus.pred_pc;
    if (fl) begin
      mq.delete();
      if (!m_req || hit) begin m_pc = tgt; m_req = 1'b1; m_drop = 1'b0; end
      else begin m_drop = 1'b1; m_rpc = tgt; end
    end else if (m_drop) begin
      if (pop) void'(mq.pop_front());
      if (hit) begin m_pc = m_rpc; m_drop = 1'b0; end
    end else begin
      if (pop) void'(mq.pop_front());
      if (hit) begin
        e.instr = bus.fetch_resp_instr;
        e.addr  = m_pc;
        mq.push_back(e);
        m_pc = m_pc + 4;
      end
      m_req = (mq.size() < DEPTH);
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("fetch_req", 64'(bus.fetch_req), 64'(m_req));
    chk("fetch_pc", 64'(bus.fetch_pc), 64'(m_pc));
    chk("count", 64'(bus.count), 64'(mq.size()));
    chk("instr_valid", 64'(bus.instr_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("instr", 64'(bus.instr), 64'(mq[0].instr));
      chk("instr_addr", 64'(bus.instr_addr), 64'(mq[0].addr));
    end
  endtask

  task automatic idle();
    bus.rdy = 1'b1; bus.rob_clear = 1'b0; bus.back_pc = '0;
    bus.fetch_resp_valid = 1'b0; bus.fetch_resp_instr = '0;
    bus.instr_issued = 1'b0; bus.pred_redirect = 1'b0; bus.pred_pc = '0;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    m_step();
    check_all();
  endtask

  task automatic respond(logic [IW-1:0] ins);
    bus.fetch_resp_valid = 1'b1; bus.fetch_resp_instr = ins;
    cycle();
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    check_all();
    rst = 1'b0;
  endtask

  logic [AW-1:0] held_pc;

  initial begin
    total = 0; bad = 0;
    idle();
    do_reset();
    chk("rst_instr", 64'(bus.instr), 64'h0);
    chk("rst_addr", 64'(bus.instr_addr), 64'h0);
    chk("rst_req", 64'(bus.fetch_req), 64'h1);

    // sequential fill, cache answers one cycle after each request
    for (int i = 0; i < 4; i++) begin
      cycle();
      respond(m_pc);
      chk("fill_pc", 64'(bus.fetch_pc), 64'(4*(i+1)));
    end
    chk("full_count", 64'(bus.count), 64'd4);
    chk("full_req", 64'(bus.fetch_req), 64'h0);
    chk("full_head", 64'(bus.instr_addr), 64'h0);

    // single pop from full queue resumes fetch at 16
    bus.instr_issued = 1'b1; cycle(); idle();
    chk("pop_count", 64'(bus.count), 64'd3);
    chk("pop_req", 64'(bus.fetch_req), 64'h1);
    chk("pop_pc", 64'(bus.fetch_pc), 64'h10);
    chk("pop_head", 64'(bus.instr_addr), 64'h4);
    respond(32'h10);
    chk("refill_count", 64'(bus.count), 64'd4);

    // rob_clear while request at 8 is in flight
    do_reset();
    respond(32'h0);
    respond(32'h4);
    cycle();
    bus.rob_clear = 1'b1; bus.back_pc = 32'h100; cycle(); idle();
    chk("fl_count", 64'(bus.count), 64'd0);
    chk("fl_pc_hold", 64'(bus.fetch_pc), 64'h8);
    cycle();
    respond(32'h8);
    chk("drop_count", 64'(bus.count), 64'd0);
    chk("drop_pc", 64'(bus.fetch_pc), 64'h100);
    respond(32'h100);
    chk("redir_head", 64'(bus.instr_addr), 64'h100);

    // rob_clear beats predicted redirect
    bus.instr_issued = 1'b1; bus.pred_redirect = 1'b1; bus.pred_pc = 32'h40;
    bus.rob_clear = 1'b1; bus.back_pc = 32'h80;
    cycle(); idle();
    chk("prio_count", 64'(bus.count), 64'd0);
    respond(32'h104);
    chk("prio_pc", 64'(bus.fetch_pc), 64'h80);
    respond(32'h80);
    chk("prio_head", 64'(bus.instr_addr), 64'h80);

    // response and rob_clear in the same cycle
    bus.rob_clear = 1'b1; bus.back_pc = 32'h20;
    respond(32'h84);
    chk("same_count", 64'(bus.count), 64'd0);
    chk("same_pc", 64'(bus.fetch_pc), 64'h20);
    respond(32'h20);
    chk("same_head", 64'(bus.instr_addr), 64'h20);
    chk("same_next_pc", 64'(bus.fetch_pc), 64'h24);

    // rdy=0 freeze with noisy inputs, then asynchronous reset mid-request
    respond(32'h24);
    held_pc = m_pc;
    for (int i = 0; i < 5; i++) begin
      bus.rdy = 1'b0; bus.rob_clear = 1'($urandom); bus.back_pc = $urandom;
      bus.fetch_resp_valid = 1'b1; bus.fetch_resp_instr = $urandom;
      bus.instr_issued = 1'($urandom); bus.pred_redirect = 1'($urandom);
      cycle();
      chk("frz_pc", 64'(bus.fetch_pc), 64'(held_pc));
      chk("frz_count", 64'(bus.count), 64'd2);
    end
    idle();
    cycle();
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", 64'(bus.fetch_pc), 64'(RPC));
    chk("arst_count", 64'(bus.count), 64'd0);
    chk("arst_req", 64'(bus.fetch_req), 64'h1);
    chk("arst_valid", 64'(bus.instr_valid), 64'h0);
    m_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.rdy              = ($urandom_range(0, 9) != 0);
      bus.fetch_resp_valid = ($urandom_range(0, 2) == 0);
      bus.fetch_resp_instr = $urandom;
      bus.instr_issued     = ($urandom_range(0, 1) == 0);
      bus.pred_redirect    = ($urandom_range(0, 5) == 0);
      bus.pred_pc          = $urandom & 32'hFFFF_FFFC;
      bus.rob_clear        = ($urandom_range(0, 39) == 0);
      bus.back_pc          = $urandom & 32'hFFFF_FFFC;
      cycle();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
